// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, keeps at most one instruction-memory request in flight
// and buffers one returned instruction for decode. Branch redirects can arrive in any state.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PCSrc_F,
  input  logic [63:0]        PCBranch_F,
  input  logic               stall_D,
  output logic               imem_req,
  output logic [63:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid_D,
  output logic [INSTR_W-1:0] instr_D,
  output logic [63:0]        pc_D,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;

  state_t               state, state_nxt;
  logic [63:0]          pc, pc_nxt, pc_inflight, pc_inflight_nxt, pc_D_nxt;
  logic                 discard, discard_nxt, valid_nxt;
  logic [INSTR_W-1:0]   instr_nxt;
  logic [31:0]          count_nxt;

  // Branch targets are word aligned; the low bits are dropped on purpose.
  logic unused_br_lsb;
  assign unused_br_lsb = ^PCBranch_F[1:0];

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pc_inflight_nxt = pc_inflight;
    discard_nxt     = discard;
    valid_nxt       = instr_valid_D;
    instr_nxt       = instr_D;
    pc_D_nxt        = pc_D;
    count_nxt       = fetch_count;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (imem_gnt) begin
          pc_inflight_nxt = pc;
          pc_nxt          = pc + 64'd4;
          discard_nxt     = PCSrc_F;  // granted request is wrong path if redirected now
          state_nxt       = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (discard || PCSrc_F) begin
            discard_nxt = 1'b0;
            state_nxt   = REQ;
          end else begin
            instr_nxt = imem_rdata;
            pc_D_nxt  = pc_inflight;
            valid_nxt = 1'b1;
            state_nxt = OUT;
          end
        end else if (PCSrc_F) begin
          discard_nxt = 1'b1;
        end
      end
      OUT: begin
        if (PCSrc_F) begin
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end else if (!stall_D) begin
          count_nxt = fetch_count + 32'd1;
          valid_nxt = 1'b0;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Redirect overrides any sequential PC update, whatever the state.
    if (PCSrc_F) pc_nxt = {PCBranch_F[63:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= {RESET_PC[63:2], 2'b00};
      pc_inflight   <= '0;
      discard       <= 1'b0;
      instr_valid_D <= 1'b0;
      instr_D       <= '0;
      pc_D          <= '0;
      fetch_count   <= '0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      pc_inflight   <= pc_inflight_nxt;
      discard       <= discard_nxt;
      instr_valid_D <= valid_nxt;
      instr_D       <= instr_nxt;
      pc_D          <= pc_D_nxt;
      fetch_count   <= count_nxt;
    end
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch for the processor front end against an instruction memory with a request/grant/response handshake.
- Owns the PC and allows at most one outstanding memory request.
- Buffers one returned instruction for decode.
- Applies branch redirects (PCSrc_F/PCBranch_F) at any point, discarding wrong-path requests and responses.
- Sits between the fetch-stage PC logic and the instruction memory port.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
INSTR_W, 32, instruction width.

Ports:
clk  in  1  clock, all state updates on posedge.
reset  in  1  synchronous, active-low: reset==0 at posedge resets the block.
PCSrc_F  in  1  branch taken; redirect fetch to PCBranch_F.
PCBranch_F  in  64  redirect target.
stall_D  in  1  decode cannot accept the buffered instruction this cycle.
imem_req  out  1  memory request valid.
imem_addr  out  64  request address (word aligned).
imem_gnt  in  1  memory accepts the request this cycle.
imem_rvalid  in  1  response data valid.
imem_rdata  in  INSTR_W  response instruction.
instr_valid_D  out  1  instr_D/pc_D hold a valid instruction.
instr_D  out  INSTR_W  buffered instruction.
pc_D  out  64  address of instr_D.
fetch_count  out  32  instructions delivered to decode; wraps 2^32-1 -> 0.

Behaviour:
Reset (reset==0 at posedge), from any state:
- state=IDLE, pc=RESET_PC, discard=0.
- instr_valid_D=0, instr_D=0, pc_D=0, fetch_count=0.
- imem_req=0 while in IDLE.

States:
- IDLE: next cycle -> REQ. A PCSrc_F seen here still loads pc.
- REQ: imem_req=1, imem_addr=pc. Address is combinational from pc.
  - imem_gnt=1: pc_inflight<=imem_addr, pc<=pc+4, go WAIT.
- WAIT: imem_req=0. imem_rvalid is accepted only in this state and is ignored elsewhere.
  - imem_rvalid=1 and discard=1: drop data, discard<=0, go REQ.
  - imem_rvalid=1 and discard=0: instr_D<=imem_rdata, pc_D<=pc_inflight, instr_valid_D<=1, go OUT.
- OUT: instr_valid_D=1, outputs stable.
  - stall_D=0 at posedge: consumed; fetch_count++, instr_valid_D<=0, go REQ.
  - stall_D=1: hold, no change.

Latency and alignment:
- Zero-wait memory (gnt in the same cycle as req, rvalid the next cycle): request-to-valid is 2 cycles, so one instruction every 3 cycles.
- PC arithmetic is 64-bit modulo: pc+4 wraps 64'hFFFF_FFFF_FFFF_FFFC -> 0.
- pc[1:0] is always forced to 2'b00; PCBranch_F[1:0] is ignored.

Redirect (PCSrc_F=1 at posedge, reset deasserted):
- pc <= {PCBranch_F[63:2],2'b00} in every state, overriding pc+4.
- REQ, gnt=0: no state change; the next cycle requests the new pc.
- REQ, gnt=1 same cycle: go WAIT with discard<=1, since the granted request is wrong path.
- WAIT: discard<=1. If rvalid arrives in the same cycle, drop it and go REQ.
- OUT: buffered instruction dropped regardless of stall_D; instr_valid_D<=0, fetch_count unchanged, go REQ.
- Redirect plus consume in the same cycle: the redirect wins; no count increment.
- Back-to-back redirects: the last target wins, and at most one response is discarded.

Reset mid-operation:
- Discards any outstanding request.
- The memory shares the same reset; a stale rvalid arriving in IDLE or REQ is ignored.

Test Plan:
1. Reset/release: hold reset=0 for 5 cycles with RESET_PC=0 -> imem_req=0, instr_valid_D=0, fetch_count=0. Release with zero-wait memory -> requests at addresses 0,4,8,... every 3 cycles; pc_D sequence 0,4,8; fetch_count 1,2,3.
2. Redirect in OUT with stall_D=1: assert PCSrc_F=1, PCBranch_F=64'h16e10b5ef5732a68 while instr at pc_D=8 is held -> instr_valid_D=0 next cycle, next imem_addr=64'h16e10b5ef5732a68, fetch_count unchanged, then 64'h16e10b5ef5732a6c.
3. Redirect during WAIT (rvalid delayed 3 cycles): PCSrc_F=1, PCBranch_F=64'h100 -> returned data dropped, no instr_valid_D pulse, next request at 64'h100.
4. Redirect coincident with gnt: req at 64'h10, gnt=1 and PCSrc_F=1 (target 64'h203) -> response discarded, next request at 64'h200.
5. Stall and grant backpressure: stall_D=1 for 4 cycles -> instr_D/pc_D stable, no new request. Hold gnt=0 for 3 cycles -> imem_req=1 with stable imem_addr.
6. Reset mid-WAIT: reset=0 for one posedge while in WAIT, then a stale rvalid -> back to IDLE, stale data ignored, first request at RESET_PC, fetch_count=0.
